// File: rtl/handshake_receiver.sv
// handshake_receiver: four-phase dav_/rfd responder feeding a DEPTH-entry FIFO.
// Optional: define DAV_SYNC_EN to pass dav_ through a two-flop synchronizer
// (reset to 1), adding two cycles of latency to every FSM decision.
module handshake_receiver #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       dav_,
    input  logic [WIDTH-1:0]           byte_in,
    output logic                       rfd,
    output logic [WIDTH-1:0]           data_out,
    output logic                       out_valid,
    input  logic                       out_ack,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_SETTLE,
        S_READY,
        S_BUSY,
        S_FULL
    } state_t;

    state_t            state, state_next;
    logic              dav_s;
    logic              wr_en;
    logic              pop_en;
    logic [CW-1:0]     count_next;
    logic [AW-1:0]     head, tail;
    logic [WIDTH-1:0]  mem [DEPTH];

`ifdef DAV_SYNC_EN
    logic dav_meta;

    // Two-flop synchronizer; idles at 1 so reset never looks like a request
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dav_meta <= 1'b1;
            dav_s    <= 1'b1;
        end else begin
            dav_meta <= dav_;
            dav_s    <= dav_meta;
        end
    end
`else
    assign dav_s = dav_;
`endif

    assign wr_en     = (state == S_READY) && !dav_s;
    assign pop_en    = out_valid && out_ack;
    assign out_valid = (count != '0);
    assign data_out  = mem[head];

    // Occupancy after this edge's write/pop; steers the BUSY/FULL exits
    always_comb begin
        count_next = count;
        case ({wr_en, pop_en})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Next-state logic for the responder side of the handshake
    always_comb begin
        state_next = state;
        case (state)
            S_SETTLE: if (dav_s) state_next = S_READY;
            S_READY:  if (!dav_s) state_next = S_BUSY;
            S_BUSY:   if (dav_s) state_next = (count_next < CW'(DEPTH)) ? S_READY : S_FULL;
            S_FULL:   if (count_next < CW'(DEPTH)) state_next = S_READY;
            default:  state_next = S_SETTLE;
        endcase
    end

    // State register; rfd is registered alongside it so it tracks S_READY exactly
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_SETTLE;
            rfd   <= 1'b0;
        end else begin
            state <= state_next;
            rfd   <= (state_next == S_READY);
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            count <= count_next;
            if (wr_en) begin
                mem[tail] <= byte_in;
                tail      <= tail + 1'b1;
            end
            if (pop_en) begin
                head <= head + 1'b1;
            end
        end
    end

endmodule
